mux2_arbiter: RTL



---
 rtl/mux2_arbiter_pkg.sv | 23 ++
 rtl/mux2to1.sv | 11 +
 rtl/mux2_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared types for the two-requester burst arbiter: FSM state encoding,
// default data width and a small helper that maps a requester index to its state.
package mux2_arbiter_pkg;

    localparam int W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_e;

    function automatic state_e own_state(input logic who);
        state_e st;
        if (who) begin
            st = OWN1;
        end else begin
            st = OWN0;
        end
        return st;
    endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer; the datapath primitive steered by the arbiter.
module mux2to1 (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);

    assign y = s ? i1 : i0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 datapath between two valid/ready
// requesters, with a single-entry registered output stage.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int W          = W_DEFAULT,
    parameter int FIRST_PRIO = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    input  logic         req0_last,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    input  logic         req1_last,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         sel,
    output logic         busy
);

    localparam logic FIRST_PRIO_B = (FIRST_PRIO != 0) ? 1'b1 : 1'b0;

    state_e         state_r;
    state_e         state_nxt_s;
    logic           ptr_r;
    logic           ptr_nxt_s;
    logic           sel_r;
    logic           busy_r;
    logic           out_valid_r;
    logic [W-1:0]   out_data_r;
    logic           out_last_r;
    logic           out_free_s;
    logic           xfer0_s;
    logic           xfer1_s;
    logic           load_s;
    logic [W-1:0]   mux_data_s;
    logic           mux_last_s;

    // The output slot can take a beat when empty or when it drains this cycle.
    assign out_free_s = !out_valid_r || out_ready;
    assign req0_ready = (state_r == OWN0) && out_free_s;
    assign req1_ready = (state_r == OWN1) && out_free_s;
    assign xfer0_s    = req0_valid && req0_ready;
    assign xfer1_s    = req1_valid && req1_ready;
    assign load_s     = xfer0_s || xfer1_s;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_data_mux
            mux2to1 u_mux_data (
                .i0 (req0_data[gi]),
                .i1 (req1_data[gi]),
                .s  (sel_r),
                .y  (mux_data_s[gi])
            );
        end
    endgenerate

    mux2to1 u_mux_last (
        .i0 (req0_last),
        .i1 (req1_last),
        .s  (sel_r),
        .y  (mux_last_s)
    );

    // Arbitration: pick an owner from IDLE, and re-arbitrate in the same cycle
    // a last beat transfers so back-to-back bursts see no bubble.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_nxt_s = own_state(ptr_r);
                end else if (req0_valid) begin
                    state_nxt_s = OWN0;
                end else if (req1_valid) begin
                    state_nxt_s = OWN1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OWN0: begin
                if (xfer0_s && req0_last) begin
                    ptr_nxt_s = 1'b1;
                    if (req1_valid) begin
                        state_nxt_s = OWN1;
                    end else if (req0_valid) begin
                        state_nxt_s = OWN0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = OWN0;
                end
            end
            OWN1: begin
                if (xfer1_s && req1_last) begin
                    ptr_nxt_s = 1'b0;
                    if (req0_valid) begin
                        state_nxt_s = OWN0;
                    end else if (req1_valid) begin
                        state_nxt_s = OWN1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = OWN1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = FIRST_PRIO_B;
            end
        endcase
    end

    // State, pointer and the registered sel/busy; sel keeps its value through IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= FIRST_PRIO_B;
            sel_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            if (state_nxt_s == OWN1) begin
                sel_r <= 1'b1;
            end else if (state_nxt_s == OWN0) begin
                sel_r <= 1'b0;
            end else begin
                sel_r <= sel_r;
            end
        end
    end

    // Single-entry output stage: load wins over drain so a beat can replace
    // the previous one with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_data_s;
            out_last_r  <= mux_last_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign sel       = sel_r;
    assign busy      = busy_r;

endmodule
